// File: rtl/periph_pkg.sv
// Shared register-map offsets and TCON bit positions for the periph_bus peripheral window.
package periph_pkg;

   localparam logic [4:0] OFF_TH      = 5'h00;
   localparam logic [4:0] OFF_TL      = 5'h04;
   localparam logic [4:0] OFF_TCON    = 5'h08;
   localparam logic [4:0] OFF_LEDS    = 5'h0C;
   localparam logic [4:0] OFF_DIGI    = 5'h10;
   localparam logic [4:0] OFF_SYSTICK = 5'h14;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

endpackage

// File: rtl/periph_timer.sv
// Reloadable 32-bit timer (TH/TL/TCON) with CPU-write priority over the hardware update.
// Optional interrupt status/enable and registered irq output under TIMER_IRQ_EN.
module periph_timer
   import periph_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we_th_i,
   input  logic        we_tl_i,
   input  logic        we_tcon_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] th_o,
   output logic [31:0] tl_o,
   output logic [31:0] tcon_o
`ifdef TIMER_IRQ_EN
   ,output logic       irq_o
`endif
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic        en_q, en_d;
   logic        wrap;
`ifdef TIMER_IRQ_EN
   logic        ie_q, ie_d;
   logic        is_q, is_d;
   logic        irq_q;
`endif

   assign wrap = en_q && (tl_q == 32'hFFFF_FFFF);

   // Hardware update first, then a same-cycle CPU write overrides it.
   always_comb begin
      th_d = we_th_i ? wdata_i : th_q;
      tl_d = tl_q;
      if (en_q) tl_d = wrap ? th_q : tl_q + 32'd1;
      if (we_tl_i) tl_d = wdata_i;
      en_d = we_tcon_i ? wdata_i[TCON_EN] : en_q;
`ifdef TIMER_IRQ_EN
      ie_d = ie_q;
      is_d = is_q;
      if (wrap && ie_q) is_d = 1'b1;
      if (we_tcon_i) begin
         ie_d = wdata_i[TCON_IE];
         is_d = wdata_i[TCON_IS];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         th_q  <= '0;
         tl_q  <= '0;
         en_q  <= 1'b0;
`ifdef TIMER_IRQ_EN
         ie_q  <= 1'b0;
         is_q  <= 1'b0;
         irq_q <= 1'b0;
`endif
      end else begin
         th_q  <= th_d;
         tl_q  <= tl_d;
         en_q  <= en_d;
`ifdef TIMER_IRQ_EN
         ie_q  <= ie_d;
         is_q  <= is_d;
         irq_q <= is_q & ie_q;
`endif
      end
   end

   always_comb begin
      tcon_o          = '0;
      tcon_o[TCON_EN] = en_q;
`ifdef TIMER_IRQ_EN
      tcon_o[TCON_IE] = ie_q;
      tcon_o[TCON_IS] = is_q;
`endif
   end

   assign th_o = th_q;
   assign tl_o = tl_q;
`ifdef TIMER_IRQ_EN
   assign irq_o = irq_q;
`endif

endmodule

// File: rtl/periph_bus.sv
// Memory-mapped peripheral window: address decode, LED/DIGI registers, SYSTICK and read mux.
// Define TIMER_IRQ_EN to get the timer interrupt enable/status bits and the irq port.
module periph_bus
   import periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          LED_W     = 8,
   parameter int          DIGI_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       Address,
   input  logic [31:0]       Write_data,
   output logic [31:0]       Read_data,
   output logic              Hit,
   output logic [LED_W-1:0]  leds,
   output logic [DIGI_W-1:0] digi
`ifdef TIMER_IRQ_EN
   ,output logic             irq
`endif
);

   logic [29:0]       woff;
   logic [4:0]        reg_off;
   logic              wr_en;
   logic              unused_byte_bits;
   logic [LED_W-1:0]  leds_q;
   logic [DIGI_W-1:0] digi_q;
   logic [31:0]       systick_q;
   logic [31:0]       th, tl, tcon;

   // Byte-lane bits never take part in decode.
   assign unused_byte_bits = ^Address[1:0];

   assign woff    = Address[31:2] - BASE_ADDR[31:2];
   assign Hit     = (Address[31:2] >= BASE_ADDR[31:2]) && (woff[29:3] == 27'd0);
   assign reg_off = {woff[2:0], 2'b00};
   assign wr_en   = Hit && MemWrite;

   periph_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .we_th_i   (wr_en && (reg_off == OFF_TH)),
      .we_tl_i   (wr_en && (reg_off == OFF_TL)),
      .we_tcon_i (wr_en && (reg_off == OFF_TCON)),
      .wdata_i   (Write_data),
      .th_o      (th),
      .tl_o      (tl),
      .tcon_o    (tcon)
`ifdef TIMER_IRQ_EN
      ,.irq_o    (irq)
`endif
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         leds_q    <= '0;
         digi_q    <= '0;
         systick_q <= '0;
      end else begin
         systick_q <= systick_q + 32'd1;
         if (wr_en && (reg_off == OFF_LEDS)) leds_q <= Write_data[LED_W-1:0];
         if (wr_en && (reg_off == OFF_DIGI)) digi_q <= Write_data[DIGI_W-1:0];
      end
   end

   // Reserved offsets fall through to zero.
   always_comb begin
      Read_data = '0;
      if (Hit && MemRead) begin
         case (reg_off)
            OFF_TH:      Read_data = th;
            OFF_TL:      Read_data = tl;
            OFF_TCON:    Read_data = tcon;
            OFF_LEDS:    Read_data[LED_W-1:0] = leds_q;
            OFF_DIGI:    Read_data[DIGI_W-1:0] = digi_q;
            OFF_SYSTICK: Read_data = systick_q;
            default:     Read_data = '0;
         endcase
      end
   end

   assign leds = leds_q;
   assign digi = digi_q;

endmodule

// File: tb/tb_periph_bus.sv
// Directed self-checking bench for periph_bus; irq checks are active when TIMER_IRQ_EN is defined.
`timescale 1ns/1ps
module tb_periph_bus;

   localparam logic [31:0] B = 32'h4000_0000;
   localparam logic [31:0] A_TH = B + 32'h00, A_TL = B + 32'h04, A_TCON = B + 32'h08;
   localparam logic [31:0] A_LEDS = B + 32'h0C, A_DIGI = B + 32'h10, A_SYS = B + 32'h14;
`ifdef TIMER_IRQ_EN
   localparam logic [31:0] TCON3 = 32'd3, TCON7 = 32'd7;
`else
   localparam logic [31:0] TCON3 = 32'd1, TCON7 = 32'd1;
`endif

   logic        clk = 1'b0;
   logic        reset, MemRead, MemWrite;
   logic [31:0] Address, Write_data, Read_data;
   logic        Hit;
   logic [7:0]  leds;
   logic [11:0] digi;
`ifdef TIMER_IRQ_EN
   logic        irq;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_tick;

   always #50 clk = ~clk;

   periph_bus dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .Hit        (Hit),
      .leds       (leds),
      .digi       (digi)
`ifdef TIMER_IRQ_EN
      ,.irq       (irq)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      logic r;
      r = reset;
      @(posedge clk);
      #1;
      exp_tick = r ? 32'd0 : exp_tick + 32'd1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string tag);
      Address = a;
      MemRead = 1'b1;
      #1;
      chk(tag, Read_data, expv);
      MemRead = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Address    = a;
      Write_data = d;
      MemWrite   = 1'b1;
      step();
      MemWrite   = 1'b0;
   endtask

   task automatic hit_chk(input logic [31:0] a, input logic expv, input string tag);
      Address = a;
      #1;
      chk(tag, {31'd0, Hit}, {31'd0, expv});
   endtask

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      Address = '0; Write_data = '0; exp_tick = '0;
      repeat (3) step();

      Address = B;
      #1;
      chk("idle_rdata", Read_data, 32'd0);
      chk("rst_leds", {24'd0, leds}, 32'd0);
      chk("rst_digi", {20'd0, digi}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         rd(B + 32'(4 * i), 32'd0, "rst_read");
         hit_chk(B + 32'(4 * i), 1'b1, "hit_in");
      end
      hit_chk(32'h4000_0020, 1'b0, "hit_above");
      hit_chk(32'h3FFF_FFFC, 1'b0, "hit_below");

      reset = 1'b0;
      step();
      rd(A_SYS, 32'd1, "systick_first");

      wr(A_LEDS, 32'hFFFF_FFA5);
      chk("leds_out", {24'd0, leds}, 32'h0000_00A5);
      rd(A_LEDS, 32'h0000_00A5, "leds_read");
      wr(A_DIGI, 32'hFFFF_F123);
      chk("digi_out", {20'd0, digi}, 32'h0000_0123);
      rd(A_DIGI, 32'h0000_0123, "digi_read");
      wr(A_SYS, 32'h0000_0000);
      rd(A_SYS, exp_tick, "systick_ro");
      wr(B + 32'h18, 32'hFFFF_FFFF);
      rd(B + 32'h18, 32'd0, "reserved_read");

      wr(A_TH, 32'hFFFF_FFF0);
      wr(A_TL, 32'hFFFF_FFFE);
      wr(A_TCON, 32'd3);
      step();
      rd(A_TL, 32'hFFFF_FFFF, "tl_max");
      step();
      rd(A_TL, 32'hFFFF_FFF0, "tl_reload");
      rd(A_TCON, TCON7, "tcon_status");
`ifdef TIMER_IRQ_EN
      chk("irq_not_yet", {31'd0, irq}, 32'd0);
`endif
      step();
`ifdef TIMER_IRQ_EN
      chk("irq_rise", {31'd0, irq}, 32'd1);
`endif
      rd(A_TL, 32'hFFFF_FFF1, "tl_after_reload");

      wr(A_TCON, 32'd3);
      rd(A_TCON, TCON3, "tcon_clear");
`ifdef TIMER_IRQ_EN
      chk("irq_hold", {31'd0, irq}, 32'd1);
      step();
      chk("irq_fall", {31'd0, irq}, 32'd0);
`endif
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TCON, 32'd3);
      rd(A_TCON, TCON3, "tcon_collide");
      rd(A_TL, 32'hFFFF_FFF0, "tl_collide_reload");
`ifdef TIMER_IRQ_EN
      step();
      chk("irq_collide", {31'd0, irq}, 32'd0);
`endif
      wr(A_TL, 32'd5);
      rd(A_TL, 32'd5, "tl_write_override");
      step();
      rd(A_TL, 32'd6, "tl_after_write");

      repeat (100) step();
      rd(A_TL, 32'd106, "tl_100");
      reset      = 1'b1;
      Address    = A_LEDS;
      Write_data = 32'h0000_00FF;
      MemWrite   = 1'b1;
      step();
      MemWrite   = 1'b0;
      rd(A_TL, 32'd0, "rst_tl");
      rd(A_TH, 32'd0, "rst_th");
      rd(A_TCON, 32'd0, "rst_tcon");
      rd(A_SYS, 32'd0, "rst_systick");
      chk("rst_leds_discard", {24'd0, leds}, 32'd0);
`ifdef TIMER_IRQ_EN
      chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
      reset = 1'b0;
      step();
      rd(A_SYS, 32'd1, "systick_release");
      rd(A_TL, 32'd0, "tl_hold_disabled");

      Address    = A_LEDS;
      Write_data = 32'h0000_003C;
      MemRead    = 1'b1;
      MemWrite   = 1'b1;
      #1;
      chk("rw_old", Read_data, 32'd0);
      step();
      MemWrite   = 1'b0;
      #1;
      chk("rw_new", Read_data, 32'h0000_003C);
      MemRead    = 1'b0;

      wr(A_TCON, 32'd7);
      rd(A_TCON, TCON7, "tcon_write7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
